icebus_status_poller: RTL

Avalon-MM master that is the initiator side of the motor-control register block's bus. On a fixed-rate tick it sweeps every motor, reads position, velocity, displacement and current, and emits each value as a valid/ready sample stream. A single-entry write port lets firmware logic push gain, setpoint and limit writes through the same master, interleaved between sweep reads.

---
 rtl/icebus_pkg.sv | 44 ++++
 rtl/poll_tick_gen.sv | 23 ++
 rtl/icebus_status_poller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/icebus_pkg.sv
// Shared constants, address helpers and FSM state type for the icebus poller.
package icebus_pkg;

  // Control-block register offsets.
  localparam logic [7:0] REG_KP  = 8'h01;
  localparam logic [7:0] REG_SP  = 8'h0C;
  localparam logic [7:0] REG_POS = 8'h04;
  localparam logic [7:0] REG_VEL = 8'h05;
  localparam logic [7:0] REG_DIS = 8'h06;
  localparam logic [7:0] REG_CUR = 8'h07;

  // Write-port register selects.
  localparam logic [7:0] WSEL_KP        = 8'd0;
  localparam logic [7:0] WSEL_KI        = 8'd1;
  localparam logic [7:0] WSEL_KD        = 8'd2;
  localparam logic [7:0] WSEL_SP        = 8'd3;
  localparam logic [7:0] WSEL_PWM_LIM   = 8'd4;
  localparam logic [7:0] WSEL_INT_LIM   = 8'd5;
  localparam logic [7:0] WSEL_DEADBAND  = 8'd6;
  localparam logic [7:0] WSEL_CTRL_MODE = 8'd7;

  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_PUSH
  } poll_state_e;

  function automatic logic [15:0] read_addr(input logic [7:0] motor, input logic [7:0] offset);
    return {motor, offset};
  endfunction

  function automatic logic [15:0] write_addr(input logic [7:0] sel, input logic [7:0] motor);
    return {sel, motor};
  endfunction

  // Sweep slot 0..3 maps onto position..current.
  function automatic logic [7:0] read_offset(input logic [1:0] idx);
    return REG_POS + {6'd0, idx};
  endfunction

endpackage

// File: rtl/poll_tick_gen.sv
// Free-running down-counter emitting a one-cycle tick every PERIOD cycles.
module poll_tick_gen #(
  parameter int PERIOD = 50_000
) (
  input  logic clock_i,
  input  logic reset_n_i,
  output logic tick_o
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    tick_o  = (count_q == '0);
    count_d = tick_o ? CW'(PERIOD - 1) : count_q - 1'b1;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= CW'(PERIOD - 1);
    else            count_q <= count_d;
  end

endmodule

// File: rtl/icebus_status_poller.sv
// Avalon-MM master sweeping motor status registers on a fixed tick, with an
// interleaved single-entry write port.
module icebus_status_poller
  import icebus_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int CLOCK_SPEED_HZ   = 50_000_000,
  parameter int POLL_RATE_HZ     = 1000,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  output logic [15:0] avm_address_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  output logic [31:0] avm_writedata_o,
  input  logic [31:0] avm_readdata_i,
  input  logic        avm_waitrequest_i,
  input  logic        wr_req_i,
  input  logic [7:0]  wr_reg_i,
  input  logic [7:0]  wr_motor_i,
  input  logic [31:0] wr_data_i,
  output logic        wr_ack_o,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic [7:0]  sample_motor_o,
  output logic [7:0]  sample_reg_o,
  output logic [31:0] sample_data_o,
  output logic        sweep_done_o,
  output logic [15:0] err_count_o,
  output logic [7:0]  overrun_count_o
);
  localparam int         TICK_PERIOD = CLOCK_SPEED_HZ / POLL_RATE_HZ;
  localparam int         TO_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] LAST_MOTOR  = 8'(NUMBER_OF_MOTORS - 1);

  logic tick;

  poll_tick_gen #(.PERIOD(TICK_PERIOD)) u_tick (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .tick_o    (tick)
  );

  poll_state_e      state_q, state_d;
  logic [7:0]       motor_q, motor_d;
  logic [1:0]       slot_q, slot_d;
  logic             pending_q, pending_d;
  logic             in_sweep_q, in_sweep_d;
  logic [TO_W-1:0]  stall_q, stall_d;
  logic [15:0]      addr_q, addr_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             valid_q, valid_d;
  logic [7:0]       smotor_q, smotor_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [31:0]      sdata_q, sdata_d;
  logic             done_q, done_d;
  logic [15:0]      err_q, err_d;
  logic [7:0]       ovr_q, ovr_d;

  logic       last_sample;
  logic [7:0] nxt_motor;
  logic [1:0] nxt_slot;
  logic [31:0] rd_ext;

  always_comb begin
    last_sample = (motor_q == LAST_MOTOR) && (slot_q == 2'd3);
    nxt_motor   = (slot_q == 2'd3) ? motor_q + 8'd1 : motor_q;
    nxt_slot    = slot_q + 2'd1;
    rd_ext      = (slot_q == 2'd3) ? {{16{avm_readdata_i[15]}}, avm_readdata_i[15:0]}
                                   : avm_readdata_i;
  end

  always_comb begin
    state_d    = state_q;
    motor_d    = motor_q;
    slot_d     = slot_q;
    pending_d  = pending_q;
    in_sweep_d = in_sweep_q;
    stall_d    = stall_q;
    addr_d     = addr_q;
    read_d     = read_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    valid_d    = valid_q;
    smotor_d   = smotor_q;
    sreg_d     = sreg_q;
    sdata_d    = sdata_q;
    done_d     = 1'b0;
    err_d      = err_q;
    ovr_d      = ovr_q;

    // A tick that finds work already queued or running is an overrun.
    if (tick) begin
      if (pending_q || in_sweep_q) begin
        if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
      end else if (enable_i) begin
        pending_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (wr_req_i) begin
          state_d = ST_WRITE;
          write_d = 1'b1;
          addr_d  = write_addr(wr_reg_i, wr_motor_i);
          wdata_d = wr_data_i;
        end else if (pending_q) begin
          state_d    = ST_READ;
          pending_d  = 1'b0;
          in_sweep_d = 1'b1;
          motor_d    = 8'd0;
          slot_d     = 2'd0;
          read_d     = 1'b1;
          stall_d    = '0;
          addr_d     = read_addr(8'd0, REG_POS);
        end
      end
      ST_WRITE: begin
        if (!avm_waitrequest_i) begin
          write_d = 1'b0;
          if (in_sweep_q) begin
            state_d = ST_READ;
            read_d  = 1'b1;
            stall_d = '0;
            addr_d  = read_addr(motor_q, read_offset(slot_q));
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        smotor_d = motor_q;
        sreg_d   = read_offset(slot_q);
        if (!avm_waitrequest_i) begin
          read_d  = 1'b0;
          valid_d = 1'b1;
          sdata_d = rd_ext;
          state_d = ST_PUSH;
        end else if (stall_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          read_d  = 1'b0;
          valid_d = 1'b1;
          sdata_d = DEADBEEF;
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          state_d = ST_PUSH;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      ST_PUSH: begin
        if (sample_ready_i) begin
          valid_d = 1'b0;
          if (last_sample) begin
            done_d     = 1'b1;
            in_sweep_d = 1'b0;
          end else begin
            motor_d = nxt_motor;
            slot_d  = nxt_slot;
          end
          // Pending writes slip in between samples, never inside a read.
          if (wr_req_i) begin
            state_d = ST_WRITE;
            write_d = 1'b1;
            addr_d  = write_addr(wr_reg_i, wr_motor_i);
            wdata_d = wr_data_i;
          end else if (!last_sample) begin
            state_d = ST_READ;
            read_d  = 1'b1;
            stall_d = '0;
            addr_d  = read_addr(nxt_motor, read_offset(nxt_slot));
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      motor_q    <= '0;
      slot_q     <= '0;
      pending_q  <= 1'b0;
      in_sweep_q <= 1'b0;
      stall_q    <= '0;
      addr_q     <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      valid_q    <= 1'b0;
      smotor_q   <= '0;
      sreg_q     <= '0;
      sdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= '0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      motor_q    <= motor_d;
      slot_q     <= slot_d;
      pending_q  <= pending_d;
      in_sweep_q <= in_sweep_d;
      stall_q    <= stall_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      valid_q    <= valid_d;
      smotor_q   <= smotor_d;
      sreg_q     <= sreg_d;
      sdata_q    <= sdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
    end
  end

  assign avm_address_o   = addr_q;
  assign avm_read_o      = read_q;
  assign avm_write_o     = write_q;
  assign avm_writedata_o = wdata_q;
  // Ack in the accept cycle so the requester can drop wr_req before IDLE re-samples it.
  assign wr_ack_o        = write_q & ~avm_waitrequest_i;
  assign sample_valid_o  = valid_q;
  assign sample_motor_o  = smotor_q;
  assign sample_reg_o    = sreg_q;
  assign sample_data_o   = sdata_q;
  assign sweep_done_o    = done_q;
  assign err_count_o     = err_q;
  assign overrun_count_o = ovr_q;

endmodule
